// File: rtl/banked_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module : banked_ram_pkg
// Brief  : Shared types and address-split helpers for the banked RAM crossbar.
// Rev    : 1.0
// ============================================================================
package banked_ram_pkg;

    typedef struct packed {
        logic stb;
        logic we;
    } port_req_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Interleaved mode takes the bank from the word-address LSBs.
    function automatic logic [31:0] bank_sel(input logic [31:0] addr, input int addr_w,
                                             input int bw, input bit interleave);
        logic [31:0] mask;
        mask = (32'd1 << bw) - 32'd1;
        if (interleave) begin
            return addr & mask;
        end
        return (addr >> (addr_w - bw)) & mask;
    endfunction

    function automatic logic [31:0] row_sel(input logic [31:0] addr, input int addr_w,
                                            input int bw, input bit interleave);
        logic [31:0] mask;
        mask = (32'd1 << (addr_w - bw)) - 32'd1;
        if (interleave) begin
            return (addr >> bw) & mask;
        end
        return addr & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/banked_ram_xbar_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin grant; search starts at i_ptr, ascending.
// Rev    : 1.0
// ============================================================================
module rr_arbiter
    import banked_ram_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic [NUM_PORTS-1:0]          i_req,
    input  logic [idx_w(NUM_PORTS)-1:0]   i_ptr,
    output logic [NUM_PORTS-1:0]          o_grant,
    output logic [idx_w(NUM_PORTS)-1:0]   o_idx,
    output logic [idx_w(NUM_PORTS)-1:0]   o_ptr_nxt,
    output logic                          o_valid
);

    localparam int c_PW = idx_w(NUM_PORTS);

    always_comb begin
        int w_pos;
        w_pos   = 0;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_pos = (int'(i_ptr) + k) % NUM_PORTS;
            if (!o_valid && i_req[w_pos]) begin
                o_valid        = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = c_PW'(w_pos);
            end
        end
    end

    assign o_ptr_nxt = (o_idx == c_PW'(NUM_PORTS - 1)) ? '0 : o_idx + 1'b1;

endmodule
`default_nettype wire

// File: rtl/banked_ram_xbar.sv
`default_nettype none
// ============================================================================
// Module : banked_ram_xbar
// Brief  : N-port pipelined Wishbone crossbar over B single-port RAM banks.
// Rev    : 1.0
// ============================================================================
module banked_ram_xbar
    import banked_ram_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int NUM_BANKS  = 2,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int INTERLEAVE = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_PORTS-1:0]          wb_stb_i,
    input  logic [NUM_PORTS-1:0]          wb_we_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]   wb_addr_i,
    input  logic [NUM_PORTS*DATA_W/8-1:0] wb_sel_i,
    input  logic [NUM_PORTS*DATA_W-1:0]   wb_data_i,
    output logic [NUM_PORTS-1:0]          wb_stall_o,
    output logic [NUM_PORTS-1:0]          wb_ack_o,
    output logic [NUM_PORTS*DATA_W-1:0]   wb_data_o
);

    localparam int c_BW   = $clog2(NUM_BANKS);
    localparam int c_RW   = ADDR_W - c_BW;
    localparam int c_PW   = idx_w(NUM_PORTS);
    localparam int c_SW   = DATA_W / 8;
    localparam int c_ROWS = 2 ** c_RW;

    port_req_t         w_req   [NUM_PORTS];
    logic [c_BW-1:0]   w_bank  [NUM_PORTS];
    logic [c_RW-1:0]   w_row   [NUM_PORTS];
    logic [c_SW-1:0]   w_sel   [NUM_PORTS];
    logic [DATA_W-1:0] w_wdata [NUM_PORTS];

    logic [NUM_PORTS-1:0] w_gnt_mat [NUM_BANKS];
    logic [DATA_W-1:0]    w_bank_q  [NUM_BANKS];
    logic [NUM_PORTS-1:0] w_gnt;

    logic [NUM_PORTS-1:0] r_ack;
    logic [NUM_PORTS-1:0] r_rd;
    logic [c_BW-1:0]      r_bidx [NUM_PORTS];
    logic [DATA_W-1:0]    r_hold [NUM_PORTS];

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_req[p].stb = wb_stb_i[p];
            w_req[p].we  = wb_we_i[p];
            w_bank[p]    = c_BW'(bank_sel(32'(wb_addr_i[p*ADDR_W +: ADDR_W]), ADDR_W, c_BW,
                                          INTERLEAVE != 0));
            w_row[p]     = c_RW'(row_sel(32'(wb_addr_i[p*ADDR_W +: ADDR_W]), ADDR_W, c_BW,
                                         INTERLEAVE != 0));
            w_sel[p]     = wb_sel_i[p*c_SW +: c_SW];
            w_wdata[p]   = wb_data_i[p*DATA_W +: DATA_W];
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [NUM_PORTS-1:0] w_breq;
        logic [NUM_PORTS-1:0] w_bgnt;
        logic [c_PW-1:0]      w_gidx;
        logic [c_PW-1:0]      w_ptr_nxt;
        logic                 w_valid;
        logic [c_PW-1:0]      r_rr;
        logic [DATA_W-1:0]    r_mem [c_ROWS];
        logic [DATA_W-1:0]    r_q;

        // Requests are masked during reset so no bank is enabled or written.
        always_comb begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                w_breq[p] = w_req[p].stb & (w_bank[p] == c_BW'(b)) & ~rst_ni;
            end
        end

        rr_arbiter #(
            .NUM_PORTS (NUM_PORTS)
        ) u_arb (
            .i_req     (w_breq),
            .i_ptr     (r_rr),
            .o_grant   (w_bgnt),
            .o_idx     (w_gidx),
            .o_ptr_nxt (w_ptr_nxt),
            .o_valid   (w_valid)
        );

        always_ff @(posedge clk_i or posedge rst_ni) begin
            if (rst_ni) begin
                r_rr <= '0;
            end else if (w_valid) begin
                r_rr <= w_ptr_nxt;
            end
        end

        always_ff @(posedge clk_i) begin
            if (w_valid) begin
                if (w_req[w_gidx].we) begin
                    for (int l = 0; l < c_SW; l++) begin
                        if (w_sel[w_gidx][l]) begin
                            r_mem[w_row[w_gidx]][l*8 +: 8] <= w_wdata[w_gidx][l*8 +: 8];
                        end
                    end
                end else begin
                    r_q <= r_mem[w_row[w_gidx]];
                end
            end
        end

        assign w_gnt_mat[b] = w_bgnt;
        assign w_bank_q[b]  = r_q;
    end

    always_comb begin
        w_gnt = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_gnt = w_gnt | w_gnt_mat[b];
        end
    end

    assign wb_stall_o = {NUM_PORTS{rst_ni}} | (wb_stb_i & ~w_gnt);
    assign wb_ack_o   = r_ack;

    // The bank index is captured at grant so the read mux follows the request, not the bus.
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            r_ack <= '0;
            r_rd  <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_bidx[p] <= '0;
                r_hold[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_ack[p] <= w_gnt[p];
                r_rd[p]  <= w_gnt[p] & ~w_req[p].we;
                if (w_gnt[p]) begin
                    r_bidx[p] <= w_bank[p];
                end
                if (r_ack[p] && r_rd[p]) begin
                    r_hold[p] <= w_bank_q[r_bidx[p]];
                end
            end
        end
    end

    always_comb begin
        wb_data_o = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            wb_data_o[p*DATA_W +: DATA_W] = (r_ack[p] && r_rd[p]) ? w_bank_q[r_bidx[p]]
                                                                  : r_hold[p];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_banked_ram_xbar.sv
`default_nettype none
// ============================================================================
// Module : tb_banked_ram_xbar
// Brief  : Self-checking bench: 2x2 contiguous and 4x4 interleaved crossbars.
// Rev    : 1.0
// ============================================================================
module tb_banked_ram_xbar;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    int          cfg;
    logic [3:0]  stb, we;
    logic [9:0]  addr [4];
    logic [3:0]  sel  [4];
    logic [31:0] wdat [4];

    logic [1:0]  a_stb, a_we, a_stall, a_ack;
    logic [19:0] a_addr;
    logic [7:0]  a_sel;
    logic [63:0] a_wd, a_rd;
    logic [3:0]  b_stb, b_we, b_stall, b_ack;
    logic [39:0] b_addr;
    logic [15:0] b_sel;
    logic [127:0] b_wd, b_rd;

    assign a_stb  = (cfg == 0) ? stb[1:0] : 2'b00;
    assign a_we   = we[1:0];
    assign a_addr = {addr[1], addr[0]};
    assign a_sel  = {sel[1], sel[0]};
    assign a_wd   = {wdat[1], wdat[0]};
    assign b_stb  = (cfg == 1) ? stb : 4'b0000;
    assign b_we   = we;
    assign b_addr = {addr[3], addr[2], addr[1], addr[0]};
    assign b_sel  = {sel[3], sel[2], sel[1], sel[0]};
    assign b_wd   = {wdat[3], wdat[2], wdat[1], wdat[0]};

    banked_ram_xbar #(
        .NUM_PORTS(2), .NUM_BANKS(2), .ADDR_W(10), .DATA_W(32), .INTERLEAVE(0)
    ) u_dut_a (
        .clk_i(clk), .rst_ni(rst), .wb_stb_i(a_stb), .wb_we_i(a_we), .wb_addr_i(a_addr),
        .wb_sel_i(a_sel), .wb_data_i(a_wd), .wb_stall_o(a_stall), .wb_ack_o(a_ack),
        .wb_data_o(a_rd)
    );

    banked_ram_xbar #(
        .NUM_PORTS(4), .NUM_BANKS(4), .ADDR_W(10), .DATA_W(32), .INTERLEAVE(1)
    ) u_dut_b (
        .clk_i(clk), .rst_ni(rst), .wb_stb_i(b_stb), .wb_we_i(b_we), .wb_addr_i(b_addr),
        .wb_sel_i(b_sel), .wb_data_i(b_wd), .wb_stall_o(b_stall), .wb_ack_o(b_ack),
        .wb_data_o(b_rd)
    );

    logic [3:0]  stall_v, ack_v;
    logic [31:0] rdat [4];
    always_comb begin
        if (cfg == 0) begin
            stall_v = {2'b00, a_stall};
            ack_v   = {2'b00, a_ack};
            rdat[0] = a_rd[31:0];
            rdat[1] = a_rd[63:32];
            rdat[2] = '0;
            rdat[3] = '0;
        end else begin
            stall_v = b_stall;
            ack_v   = b_ack;
            for (int p = 0; p < 4; p++) rdat[p] = b_rd[p*32 +: 32];
        end
    end

    // Reference model: flat word memory per config, defined-bit masks, per-bank rr pointer.
    logic [31:0] mem  [2][1024];
    logic [31:0] defm [2][1024];
    int          rrm  [2][4];
    logic [3:0]  exp_ack, exp_isrd, granted, obs_gnt, stall_seen;
    logic [31:0] exp_rd [4];
    logic [31:0] exp_m  [4];
    logic [31:0] last_rd [2][4];
    logic [31:0] last_m  [2][4];
    logic [31:0] obs_rd [4];
    int          checks, errors;

    function automatic int bank_of(input logic [9:0] a);
        return (cfg == 0) ? int'(a) / 512 : int'(a) % 4;
    endfunction

    function automatic logic [3:0] pmask();
        return (cfg == 0) ? 4'b0011 : 4'b1111;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < 4; p++) begin
                rrm[c][p]     = 0;
                last_rd[c][p] = '0;
                last_m[c][p]  = '1;
            end
        end
        exp_ack  = '0;
        exp_isrd = '0;
    endtask

    task automatic tick();
        logic [3:0] pm, exp_stall, win;
        int np, best, bestd, d;
        np = (cfg == 0) ? 2 : 4;
        pm = pmask();
        @(negedge clk);
        win = '0;
        if (!rst) begin
            for (int b = 0; b < np; b++) begin
                best  = -1;
                bestd = np;
                for (int p = 0; p < np; p++) begin
                    if (stb[p] && bank_of(addr[p]) == b) begin
                        d = (p - rrm[cfg][b] + np) % np;
                        if (d < bestd) begin
                            bestd = d;
                            best  = p;
                        end
                    end
                end
                if (best >= 0) begin
                    win[best]   = 1'b1;
                    rrm[cfg][b] = (best + 1) % np;
                end
            end
        end
        exp_stall  = rst ? pm : (stb & ~win & pm);
        obs_gnt    = stb & ~stall_v & pm;
        stall_seen = stall_seen | (stall_v & pm);
        checks++;
        if (stall_v !== exp_stall) begin
            errors++;
            $display("FAIL stall cfg%0d t=%0t got %b expected %b", cfg, $time, stall_v, exp_stall);
        end
        checks++;
        if (ack_v !== exp_ack) begin
            errors++;
            $display("FAIL ack cfg%0d t=%0t got %b expected %b", cfg, $time, ack_v, exp_ack);
        end
        for (int p = 0; p < np; p++) begin
            if (exp_ack[p] && exp_isrd[p]) begin
                checks++;
                obs_rd[p] = rdat[p];
                if ((rdat[p] & exp_m[p]) !== (exp_rd[p] & exp_m[p])) begin
                    errors++;
                    $display("FAIL rdata cfg%0d p%0d t=%0t got %h expected %h", cfg, p, $time,
                             rdat[p], exp_rd[p]);
                end
                last_rd[cfg][p] = exp_rd[p];
                last_m[cfg][p]  = exp_m[p];
            end else if (!exp_ack[p]) begin
                checks++;
                if ((rdat[p] & last_m[cfg][p]) !== (last_rd[cfg][p] & last_m[cfg][p])) begin
                    errors++;
                    $display("FAIL hold cfg%0d p%0d t=%0t got %h expected %h", cfg, p, $time,
                             rdat[p], last_rd[cfg][p]);
                end
            end
        end
        exp_ack  = win;
        exp_isrd = '0;
        for (int p = 0; p < np; p++) begin
            if (win[p]) begin
                if (we[p]) begin
                    for (int l = 0; l < 4; l++) begin
                        if (sel[p][l]) begin
                            mem[cfg][addr[p]][l*8 +: 8]  = wdat[p][l*8 +: 8];
                            defm[cfg][addr[p]][l*8 +: 8] = 8'hFF;
                        end
                    end
                end else begin
                    exp_isrd[p] = 1'b1;
                    exp_rd[p]   = mem[cfg][addr[p]];
                    exp_m[p]    = defm[cfg][addr[p]];
                end
            end
        end
        granted = win;
        @(posedge clk);
        #1;
    endtask

    // Each port drops its strobe once accepted; one extra cycle collects the final acks.
    task automatic run_reqs(input int budget, output int cycles);
        cycles = 0;
        while (((stb & pmask()) != 0) && cycles < budget) begin
            tick();
            stb = stb & ~granted;
            cycles++;
        end
        if ((stb & pmask()) != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout cfg%0d pending %b after %0d cycles", cfg, stb, budget);
            stb = '0;
        end
        tick();
    endtask

    task automatic set_port(input int p, input logic w, input logic [9:0] a,
                            input logic [3:0] s, input logic [31:0] d);
        stb[p]  = 1'b1;
        we[p]   = w;
        addr[p] = a;
        sel[p]  = s;
        wdat[p] = d;
    endtask

    task automatic pulse_reset();
        stb = '0;
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int cyc;
        rst = 1'b1;
        model_reset();
        cfg = 0;
        stb = 4'b1111;
        for (int p = 0; p < 4; p++) begin
            we[p]   = 1'b0;
            addr[p] = 10'($urandom_range(0, 1023));
            sel[p]  = 4'hF;
            wdat[p] = '0;
        end
        tick();
        cfg = 1;
        tick();
        rst = 1'b0;
        run_reqs(8, cyc);
        cfg = 0;
        stb = 4'b0011;
        run_reqs(8, cyc);
    endtask

    task automatic test_no_conflict();
        int cyc;
        cfg = 0;
        stb = '0;
        stall_seen = '0;
        set_port(0, 1'b1, 10'h011, 4'hF, 32'hDEADBEEF);
        set_port(1, 1'b1, 10'h211, 4'hF, 32'hCAFEF00D);
        run_reqs(8, cyc);
        checks++;
        if (cyc != 1 || stall_seen != 0) begin
            errors++;
            $display("FAIL parallel_write cycles %0d stalls %b expected 1 and 0000", cyc, stall_seen);
        end
        obs_rd[0] = '0;
        obs_rd[1] = '0;
        set_port(0, 1'b0, 10'h011, 4'hF, 32'h0);
        set_port(1, 1'b0, 10'h211, 4'hF, 32'h0);
        run_reqs(8, cyc);
        checks++;
        if (obs_rd[0] !== 32'hDEADBEEF || obs_rd[1] !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL parallel_read got %h %h expected deadbeef cafef00d", obs_rd[0], obs_rd[1]);
        end
    endtask

    task automatic test_conflict();
        int cyc;
        logic [3:0] pat [4];
        pat[0] = 4'b0001; pat[1] = 4'b0010; pat[2] = 4'b0001; pat[3] = 4'b0010;
        cfg = 0;
        stb = '0;
        set_port(0, 1'b1, 10'h022, 4'hF, 32'h12345678);
        run_reqs(8, cyc);
        pulse_reset();
        set_port(0, 1'b0, 10'h011, 4'hF, 32'h0);
        set_port(1, 1'b0, 10'h022, 4'hF, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs_gnt !== pat[i]) begin
                errors++;
                $display("FAIL rr_order cycle %0d got %b expected %b", i, obs_gnt, pat[i]);
            end
        end
        stb = '0;
        tick();
    endtask

    task automatic test_byte_lanes();
        int cyc;
        cfg = 0;
        stb = '0;
        set_port(0, 1'b1, 10'h155, 4'hF, 32'h0000_0000);
        run_reqs(8, cyc);
        set_port(0, 1'b1, 10'h155, 4'b0101, 32'hAABBCCDD);
        run_reqs(8, cyc);
        obs_rd[0] = 'x;
        set_port(0, 1'b0, 10'h155, 4'hF, 32'h0);
        run_reqs(8, cyc);
        checks++;
        if (obs_rd[0] !== 32'h00BB00DD) begin
            errors++;
            $display("FAIL byte_lanes got %h expected 00bb00dd", obs_rd[0]);
        end
    endtask

    task automatic test_interleave();
        int cyc;
        logic [31:0] val [16];
        cfg = 1;
        stb = '0;
        for (int k = 0; k < 4; k++) begin
            for (int p = 0; p < 4; p++) begin
                val[4*k+p] = $urandom;
                set_port(p, 1'b1, 10'(4*k + p), 4'hF, val[4*k+p]);
            end
            run_reqs(8, cyc);
        end
        stall_seen = '0;
        for (int p = 0; p < 4; p++) set_port(p, 1'b0, 10'(p), 4'hF, 32'h0);
        run_reqs(8, cyc);
        checks++;
        if (cyc != 1 || stall_seen != 0) begin
            errors++;
            $display("FAIL interleave_parallel cycles %0d stalls %b expected 1 and 0000", cyc, stall_seen);
        end
        for (int p = 0; p < 4; p++) begin
            obs_rd[p] = 'x;
            set_port(p, 1'b0, 10'(4*p), 4'hF, 32'h0);
        end
        run_reqs(16, cyc);
        checks++;
        if (cyc != 4) begin
            errors++;
            $display("FAIL interleave_conflict cycles %0d expected 4", cyc);
        end
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (obs_rd[p] !== val[4*p]) begin
                errors++;
                $display("FAIL interleave_data p%0d got %h expected %h", p, obs_rd[p], val[4*p]);
            end
        end
    endtask

    task automatic test_async_reset();
        int cyc;
        cfg = 0;
        stb = '0;
        set_port(0, 1'b0, 10'h011, 4'hF, 32'h0);
        for (int i = 0; i < 3; i++) tick();
        #2;
        rst = 1'b1;
        stb = '0;
        #1;
        checks++;
        if (ack_v !== 4'b0000 || rdat[0] !== 32'h0) begin
            errors++;
            $display("FAIL async_reset ack %b data %h expected 0000 and 0", ack_v, rdat[0]);
        end
        model_reset();
        tick();
        rst = 1'b0;
        tick();
        tick();
        obs_rd[0] = 'x;
        set_port(0, 1'b0, 10'h011, 4'hF, 32'h0);
        run_reqs(8, cyc);
        checks++;
        if (obs_rd[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL post_reset_read got %h expected deadbeef", obs_rd[0]);
        end
    endtask

    task automatic test_random(input int c, input int n);
        logic [3:0] held;
        int np;
        cfg = c;
        np  = (c == 0) ? 2 : 4;
        stb = '0;
        held = '0;
        for (int i = 0; i < n; i++) begin
            for (int p = 0; p < np; p++) begin
                if (!held[p]) begin
                    stb[p]  = ($urandom_range(0, 9) < 7);
                    we[p]   = $urandom_range(0, 1) == 1;
                    addr[p] = (c == 0) ? 10'($urandom_range(0, 1) * 512 + $urandom_range(0, 7))
                                       : 10'($urandom_range(0, 15));
                    sel[p]  = 4'($urandom_range(0, 15));
                    wdat[p] = $urandom;
                end
            end
            tick();
            held = stb & ~granted;
        end
        stb = '0;
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        stall_seen = '0;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 1024; i++) begin
                mem[c][i]  = '0;
                defm[c][i] = '0;
            end
        end
        test_reset();
        test_no_conflict();
        test_conflict();
        test_byte_lanes();
        test_interleave();
        test_async_reset();
        test_random(0, 300);
        test_random(1, 300);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
